error_freq_deviation_too_high: RTL and testbench



---
 rtl/error_freq_deviation_too_high_pkg.sv | 27 ++
 rtl/error_freq_deviation_too_high_if.sv | 22 ++
 rtl/error_freq_deviation_too_high_freq_mon.sv | 84 ++++++++
 rtl/error_freq_deviation_too_high.sv | 79 +++++++
 tb/tb_error_freq_deviation_too_high.sv | 138 +++++++++++++
 5 files changed

// File: rtl/error_freq_deviation_too_high_pkg.sv
// Shared constants and helpers for the frequency-checked clock divider.
package error_freq_deviation_too_high_pkg;

    localparam longint PPM_SCALE = 64'sd1_000_000;

    // Signed deviation of actual from target, in parts per million.
    function automatic longint calc_ppm(input longint actual, input longint target);
        longint ppm_v;
        if (target == 64'sd0) begin
            ppm_v = 64'sd0;
        end else begin
            ppm_v = (PPM_SCALE * (actual - target)) / target;
        end
        return ppm_v;
    endfunction

    function automatic longint abs64(input longint v);
        longint r_v;
        if (v < 64'sd0) begin
            r_v = -v;
        end else begin
            r_v = v;
        end
        return r_v;
    endfunction

endpackage

// File: rtl/error_freq_deviation_too_high_if.sv
// Output/monitor signal bundle of the frequency-checked clock divider.
interface error_freq_deviation_too_high_if;
    logic clk_o;
    logic rise_o;
    logic mon_i;
    logic err_freq_too_high_o;
    logic err_deviation_o;
    logic mon_too_high_o;
    logic mon_dev_o;

    modport master (
        output clk_o, rise_o, err_freq_too_high_o, err_deviation_o,
               mon_too_high_o, mon_dev_o,
        input  mon_i
    );

    modport slave (
        input  clk_o, rise_o, err_freq_too_high_o, err_deviation_o,
               mon_too_high_o, mon_dev_o,
        output mon_i
    );
endinterface

// File: rtl/error_freq_deviation_too_high_freq_mon.sv
// Period monitor: synchronises mon_i, measures rising-edge spacing and
// raises sticky flags when the spacing leaves EXP +/- TOL.
module freq_mon #(
    parameter int EXP = 2,
    parameter int TOL = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic mon_i,
    output logic mon_too_high_o,
    output logic mon_dev_o
);
    localparam int CNT_W   = $clog2(2 * EXP + 2) + 1;
    localparam int CNT_MAX = (32'sd1 << CNT_W) - 32'sd1;
    localparam int LO      = EXP - TOL;
    localparam int HI      = EXP + TOL;
    localparam int LO_C    = (LO < 0) ? 0 : LO;
    localparam int HI_C    = (HI > CNT_MAX) ? CNT_MAX : HI;
    localparam logic [CNT_W-1:0] LO_V = LO_C[CNT_W-1:0];
    localparam logic [CNT_W-1:0] HI_V = HI_C[CNT_W-1:0];
    localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1'b1);

    logic [1:0]       sync_r;
    logic             prev_r;
    logic             edge_r;
    logic             edge_s;
    logic             armed_r;
    logic [CNT_W-1:0] cnt_r;
    logic             too_high_r;
    logic             dev_r;
    logic             too_short_s;
    logic             out_of_tol_s;

    assign edge_s = sync_r[1] & ~prev_r;

    // Two-stage synchroniser followed by a registered rising-edge pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= 2'b00;
            prev_r <= 1'b0;
            edge_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[0], mon_i};
            prev_r <= sync_r[1];
            edge_r <= edge_s;
        end
    end

    // A saturated count means the period overflowed and is always a deviation.
    always_comb begin
        too_short_s  = 1'b0;
        out_of_tol_s = 1'b0;
        if (edge_r && armed_r) begin
            too_short_s  = (cnt_r < LO_V);
            out_of_tol_s = (cnt_r < LO_V) || (cnt_r > HI_V) || (cnt_r == '1);
        end else begin
            too_short_s  = 1'b0;
            out_of_tol_s = 1'b0;
        end
    end

    // Period counter, arming and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r      <= '0;
            armed_r    <= 1'b0;
            too_high_r <= 1'b0;
            dev_r      <= 1'b0;
        end else begin
            too_high_r <= too_high_r | too_short_s;
            dev_r      <= dev_r | out_of_tol_s;
            if (edge_r) begin
                cnt_r   <= ONE_V;
                armed_r <= 1'b1;
            end else if (cnt_r != '1) begin
                cnt_r <= cnt_r + ONE_V;
            end
        end
    end

    assign mon_too_high_o = too_high_r;
    assign mon_dev_o      = dev_r;

endmodule

// File: rtl/error_freq_deviation_too_high.sv
// Clock divider with static FREQ_I/FREQ_O checks and a runtime period monitor.
// Define FREQ_CHECK_FATAL_EN to turn static check violations into elaboration errors.
module error_freq_deviation_too_high
    import error_freq_deviation_too_high_pkg::*;
#(
    parameter int   FREQ_I  = 6_000_000,
    parameter int   FREQ_O  = 3_000_000,
    parameter logic PHASE   = 1'b1,
    parameter int   MAX_PPM = 50_000
) (
    input  logic clk,
    input  logic reset,
    error_freq_deviation_too_high_if.master bus
);
    localparam int     INIT     = FREQ_I / FREQ_O / 2 - 1;
    localparam int     INIT_EFF = (INIT < 0) ? 0 : INIT;
    localparam longint ACTUAL   = longint'(FREQ_I) / (longint'(INIT_EFF + 1) * 64'sd2);
    localparam longint PPM      = calc_ppm(ACTUAL, longint'(FREQ_O));
    localparam int     EXP      = FREQ_I / FREQ_O;
    localparam longint TOL_RAW  = (longint'(EXP) * longint'(MAX_PPM)) / PPM_SCALE;
    localparam int     TOL      = (TOL_RAW < 64'sd1) ? 1 : int'(TOL_RAW);
    localparam int     CNT_W    = $clog2(INIT_EFF) + 1;

    // A clamped divider runs below target, so the deviation is judged by magnitude.
    localparam logic ERR_HI  = (INIT < 0);
    localparam logic ERR_DEV = (abs64(PPM) > longint'(MAX_PPM));

    localparam logic [CNT_W-1:0] INIT_V = INIT_EFF[CNT_W-1:0];
    localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1'b1);

    $info("error_freq_deviation_too_high: FREQ_I=%0d FREQ_O=%0d INIT=%0d ACTUAL=%0d PPM=%0d EXP=%0d TOL=%0d",
          FREQ_I, FREQ_O, INIT, ACTUAL, PPM, EXP, TOL);

`ifdef FREQ_CHECK_FATAL_EN
    if (ERR_HI) begin : g_err_hi
        _ERROR_FREQ_TOO_HIGH_ u_err_hi ();
    end
    if (ERR_DEV) begin : g_err_dev
        _ERROR_FREQ_DEVIATION_TOO_HIGH_ u_err_dev ();
    end
`endif

    logic [CNT_W-1:0] cnt_r;
    logic             clk_o_r;
    logic             rise_r;

    // Half-period down-counter; rise_r flags the cycle clk_o_r becomes high.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= '0;
            clk_o_r <= PHASE;
            rise_r  <= 1'b0;
        end else if (cnt_r == '0) begin
            cnt_r   <= INIT_V;
            clk_o_r <= ~clk_o_r;
            rise_r  <= ~clk_o_r;
        end else begin
            cnt_r   <= cnt_r - ONE_V;
            rise_r  <= 1'b0;
        end
    end

    assign bus.clk_o               = clk_o_r;
    assign bus.rise_o              = rise_r;
    assign bus.err_freq_too_high_o = ERR_HI;
    assign bus.err_deviation_o     = ERR_DEV;

    freq_mon #(
        .EXP (EXP),
        .TOL (TOL)
    ) u_freq_mon (
        .clk            (clk),
        .reset          (reset),
        .mon_i          (bus.mon_i),
        .mon_too_high_o (bus.mon_too_high_o),
        .mon_dev_o      (bus.mon_dev_o)
    );

endmodule

// File: tb/tb_error_freq_deviation_too_high.sv
// Directed bench: several parameterisations of the divider side by side.
module tb_error_freq_deviation_too_high;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   check_cnt = 0;
    int   fail_cnt = 0;

    always #5 clk = ~clk;

    error_freq_deviation_too_high_if bus_def ();
    error_freq_deviation_too_high_if bus_div ();
    error_freq_deviation_too_high_if bus_dev ();
    error_freq_deviation_too_high_if bus_devok ();
    error_freq_deviation_too_high_if bus_hi ();

    error_freq_deviation_too_high u_def (.clk(clk), .reset(reset), .bus(bus_def));

    error_freq_deviation_too_high #(.FREQ_I(12_000_000), .FREQ_O(1_000_000), .PHASE(1'b1), .MAX_PPM(50_000))
        u_div (.clk(clk), .reset(reset), .bus(bus_div));

    error_freq_deviation_too_high #(.FREQ_I(6_000_000), .FREQ_O(4_000_000), .PHASE(1'b1), .MAX_PPM(50_000))
        u_dev (.clk(clk), .reset(reset), .bus(bus_dev));

    error_freq_deviation_too_high #(.FREQ_I(6_000_000), .FREQ_O(4_000_000), .PHASE(1'b1), .MAX_PPM(500_000))
        u_devok (.clk(clk), .reset(reset), .bus(bus_devok));

    error_freq_deviation_too_high #(.FREQ_I(6_000_000), .FREQ_O(4_000_001), .PHASE(1'b1), .MAX_PPM(50_000))
        u_hi (.clk(clk), .reset(reset), .bus(bus_hi));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Expected clk_o after the k-th edge since reset release (PHASE=1, half period h).
    function automatic logic exp_clk(input int k, input int h);
        return (((k - 1) / h) % 2) == 1;
    endfunction

    function automatic logic exp_rise(input int k, input int h);
        return (((k - 1) % h) == 0) && exp_clk(k, h);
    endfunction

    initial begin
        bus_def.mon_i   = 1'b0;
        bus_div.mon_i   = 1'b0;
        bus_dev.mon_i   = 1'b0;
        bus_devok.mon_i = 1'b0;
        bus_hi.mon_i    = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state and static check outputs
        check_val("rst_def_clk", 32'(bus_def.clk_o), 32'd1);
        check_val("rst_def_rise", 32'(bus_def.rise_o), 32'd0);
        check_val("rst_div_clk", 32'(bus_div.clk_o), 32'd1);
        check_val("rst_def_mon", {30'd0, bus_def.mon_too_high_o, bus_def.mon_dev_o}, 32'd0);
        check_val("err_def", {30'd0, bus_def.err_freq_too_high_o, bus_def.err_deviation_o}, 32'b00);
        check_val("err_div", {30'd0, bus_div.err_freq_too_high_o, bus_div.err_deviation_o}, 32'b00);
        check_val("err_dev", {30'd0, bus_dev.err_freq_too_high_o, bus_dev.err_deviation_o}, 32'b11);
        check_val("err_devok", {30'd0, bus_devok.err_freq_too_high_o, bus_devok.err_deviation_o}, 32'b10);
        check_val("err_hi", {30'd0, bus_hi.err_freq_too_high_o, bus_hi.err_deviation_o}, 32'b11);
        reset = 1'b0;

        // Divider waveforms: INIT=0 toggles every cycle, INIT=5 every six
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            check_val($sformatf("def_clk_k%0d", k), 32'(bus_def.clk_o), 32'(exp_clk(k, 1)));
            check_val($sformatf("def_rise_k%0d", k), 32'(bus_def.rise_o), 32'(exp_rise(k, 1)));
            check_val($sformatf("div_clk_k%0d", k), 32'(bus_div.clk_o), 32'(exp_clk(k, 6)));
            check_val($sformatf("div_rise_k%0d", k), 32'(bus_div.rise_o), 32'(exp_rise(k, 6)));
            check_val($sformatf("hi_clk_k%0d", k), 32'(bus_hi.clk_o), 32'(exp_clk(k, 1)));
            check_val($sformatf("dev_clk_k%0d", k), 32'(bus_dev.clk_o), 32'(exp_clk(k, 1)));
        end

        // In-tolerance periods: def 2 cycles (EXP=2), div 12 cycles (EXP=12)
        for (int i = 0; i < 60; i++) begin
            bus_def.mon_i = ~bus_def.mon_i;
            if ((i % 6) == 0) bus_div.mon_i = ~bus_div.mon_i;
            @(negedge clk);
        end
        bus_def.mon_i = 1'b0;
        bus_div.mon_i = 1'b0;
        repeat (6) @(negedge clk);
        check_val("mon_ok_def", {30'd0, bus_def.mon_too_high_o, bus_def.mon_dev_o}, 32'b00);
        check_val("mon_ok_div", {30'd0, bus_div.mon_too_high_o, bus_div.mon_dev_o}, 32'b00);

        // Too slow on def (6 cycles), too fast on div (2 cycles)
        do_reset();
        for (int i = 0; i < 36; i++) begin
            bus_div.mon_i = ~bus_div.mon_i;
            if ((i % 3) == 0) bus_def.mon_i = ~bus_def.mon_i;
            @(negedge clk);
        end
        bus_def.mon_i = 1'b0;
        bus_div.mon_i = 1'b0;
        repeat (6) @(negedge clk);
        check_val("mon_slow_def", {30'd0, bus_def.mon_too_high_o, bus_def.mon_dev_o}, 32'b01);
        check_val("mon_fast_div", {30'd0, bus_div.mon_too_high_o, bus_div.mon_dev_o}, 32'b11);

        // Reset mid-measurement discards the count and disarms the monitor
        do_reset();
        check_val("mon_rst_clear", {30'd0, bus_def.mon_too_high_o, bus_def.mon_dev_o}, 32'b00);
        bus_def.mon_i = 1'b1;
        repeat (2) @(negedge clk);
        bus_def.mon_i = 1'b0;
        repeat (4) @(negedge clk);
        do_reset();
        repeat (30) @(negedge clk);
        check_val("mon_mid_rst", {30'd0, bus_def.mon_too_high_o, bus_def.mon_dev_o}, 32'b00);
        bus_def.mon_i = 1'b1;
        repeat (5) @(negedge clk);
        bus_def.mon_i = 1'b0;
        repeat (5) @(negedge clk);
        check_val("mon_arm_only", {30'd0, bus_def.mon_too_high_o, bus_def.mon_dev_o}, 32'b00);
        bus_def.mon_i = 1'b1;
        repeat (3) @(negedge clk);
        check_val("mon_lat_pre", 32'(bus_def.mon_dev_o), 32'd0);
        @(negedge clk);
        check_val("mon_lat_dev", 32'(bus_def.mon_dev_o), 32'd1);
        check_val("mon_lat_th", 32'(bus_def.mon_too_high_o), 32'd0);
        bus_def.mon_i = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
